pc_gen: RTL and testbench

Parametrised next-PC and fetch-sequencing unit for the NPC core. It holds the architectural PC and issues one fetch request per instruction over a valid/ready handshake. It then waits for the execute stage to commit a next-PC selection, covering sequential, jump, register-jump, conditional-branch, trap and trap-return targets. It also counts retired instructions and enters a terminal halt state on request.

---
 rtl/pc_gen.sv | 142 ++++++++++++++
 tb/tb_pc_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: next-PC and fetch sequencer. Holds the architectural PC, issues one fetch per instruction, and counts retired instructions.
// Latency: a fetch issues 1 cycle after reset release. Each instruction takes at least 2 cycles (FETCH accept, then EXEC commit).
// Backpressure: o_fetch_valid/o_fetch_addr are held while i_fetch_ready is low. EXEC waits indefinitely for i_commit_valid.
//
// Ports:
//   i_clk, i_rst (sync, active-low)     clock and reset
//   o_fetch_valid/i_fetch_ready         fetch request handshake; o_fetch_addr equals o_pc
//   i_commit_valid, i_npc_sel           commit strobe and next-PC mode (0 seq,1 jal,2 jalr,3 branch,4 trap,5 mret,6/7 seq)
//   i_imm, i_result, i_mtvec, i_mepc    next-PC operands
//   i_halt_req                          enter HALT after this commit
//   o_pc, o_retired, o_misalign, o_halt architectural state and status
//
// Optional feature: define PC_GEN_MISALIGN_CHECK_EN to redirect misaligned jal/jalr/taken-branch
// targets to the trap vector and pulse o_misalign.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
  parameter int              CNT_W        = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_fetch_valid,
  input  logic             i_fetch_ready,
  output logic [XLEN-1:0]  o_fetch_addr,
  input  logic             i_commit_valid,
  input  logic [2:0]       i_npc_sel,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [XLEN-1:0]  i_result,
  input  logic [XLEN-1:0]  i_mtvec,
  input  logic [XLEN-1:0]  i_mepc,
  input  logic             i_halt_req,
  output logic [XLEN-1:0]  o_pc,
  output logic [CNT_W-1:0] o_retired,
  output logic             o_misalign,
  output logic             o_halt
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_commit;
  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_retired;
  logic [XLEN-1:0]  w_snpc;
  logic [XLEN-1:0]  w_dnpc;
  logic [XLEN-1:0]  w_trap_vec;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_npc;

  // Unchecked next-PC selection
  always_comb begin
    w_snpc     = r_pc + XLEN'(4);
    w_dnpc     = r_pc + i_imm;
    w_trap_vec = i_mtvec & ~XLEN'(3);
    w_target   = w_snpc;
    case (i_npc_sel)
      3'd1:    w_target = w_dnpc;
      3'd2:    w_target = i_result & ~XLEN'(1);
      3'd3:    w_target = (|i_result) ? w_dnpc : w_snpc;
      3'd4:    w_target = w_trap_vec;
      3'd5:    w_target = i_mepc;
      default: w_target = w_snpc;
    endcase
  end

`ifdef PC_GEN_MISALIGN_CHECK_EN
  logic w_chk;
  logic w_mis;
  logic r_misalign;

  // Only control-transfer targets computed from imm/result can be misaligned
  always_comb begin
    w_chk = (i_npc_sel == 3'd1) || (i_npc_sel == 3'd2) ||
            ((i_npc_sel == 3'd3) && (|i_result));
    w_mis = w_chk && w_target[1];
    w_npc = w_mis ? w_trap_vec : w_target;
  end

  // Pulse lands on the first cycle of the redirected FETCH
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_commit && w_mis;
    end
  end

  assign o_misalign = r_misalign;
`else
  always_comb begin
    w_npc = w_target;
  end

  assign o_misalign = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      S_BOOT:  w_state_nxt = S_FETCH;
      S_FETCH: if (i_fetch_ready) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (i_commit_valid) begin
          w_commit    = 1'b1;
          w_state_nxt = i_halt_req ? S_HALT : S_FETCH;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= S_BOOT;
      r_pc      <= RESET_VECTOR;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_commit) begin
        r_pc      <= w_npc;
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // All outputs decode registered state only
  assign o_fetch_valid = (r_state == S_FETCH);
  assign o_halt        = (r_state == S_HALT);
  assign o_fetch_addr  = r_pc;
  assign o_pc          = r_pc;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_addr;
  logic        commit_valid;
  logic [2:0]  npc_sel;
  logic [31:0] imm;
  logic [31:0] result;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        halt_req;
  logic [31:0] pc;
  logic [63:0] retired;
  logic        misalign;
  logic        halt;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_ret = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic        mis;
    logic        hlt;
  } exp_t;
  exp_t sb[$];

  localparam logic [31:0] RV = 32'h8000_0000;

  pc_gen dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_fetch_valid (fetch_valid),
    .i_fetch_ready (fetch_ready),
    .o_fetch_addr  (fetch_addr),
    .i_commit_valid(commit_valid),
    .i_npc_sel     (npc_sel),
    .i_imm         (imm),
    .i_result      (result),
    .i_mtvec       (mtvec),
    .i_mepc        (mepc),
    .i_halt_req    (halt_req),
    .o_pc          (pc),
    .o_retired     (retired),
    .o_misalign    (misalign),
    .o_halt        (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a fetch request, then accept it in one cycle
  task automatic do_fetch(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (fetch_valid === 1'b1) break;
      tick();
    end
    check({tag, "_fetch_wait"}, {63'd0, fetch_valid}, 64'd1);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    check({tag, "_exec_fv"}, {63'd0, fetch_valid}, 64'd0);
  endtask

  // Commit one instruction in EXEC; expectation queued at drive time, compared after the edge
  task automatic do_commit(input string tag, input logic [2:0] sel, input logic [31:0] imm_v,
                           input logic [31:0] res_v, input logic [31:0] mtvec_v,
                           input logic [31:0] mepc_v, input logic hreq,
                           input logic [31:0] exp_pc, input logic exp_mis);
    exp_t e;
    commit_valid = 1'b1;
    npc_sel      = sel;
    imm          = imm_v;
    result       = res_v;
    mtvec        = mtvec_v;
    mepc         = mepc_v;
    halt_req     = hreq;
    sb.push_back('{pc: exp_pc, mis: exp_mis, hlt: hreq});
    tick();
    commit_valid = 1'b0;
    halt_req     = 1'b0;
    exp_ret      = exp_ret + 64'd1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_pc"}, {32'd0, pc}, {32'd0, e.pc});
      check({tag, "_fetch_addr"}, {32'd0, fetch_addr}, {32'd0, e.pc});
      check({tag, "_retired"}, retired, exp_ret);
      check({tag, "_misalign"}, {63'd0, misalign}, {63'd0, e.mis});
      check({tag, "_halt"}, {63'd0, halt}, {63'd0, e.hlt});
      check({tag, "_fv"}, {63'd0, fetch_valid}, {63'd0, ~e.hlt});
    end
  endtask

  // Bring pc to 0x8000_0010 via mret so each mode starts from the same point
  task automatic goto_10();
    do_fetch("goto10");
    do_commit("goto10", 3'd5, 32'd0, 32'd0, 32'd0, 32'h8000_0010, 1'b0, 32'h8000_0010, 1'b0);
    do_fetch("mode");
  endtask

  initial begin
    rst = 1'b0; fetch_ready = 1'b0; commit_valid = 1'b0; npc_sel = 3'd0;
    imm = '0; result = '0; mtvec = '0; mepc = '0; halt_req = 1'b0;

    // Reset / boot
    repeat (3) tick();
    check("rst_pc", {32'd0, pc}, {32'd0, RV});
    check("rst_retired", retired, 64'd0);
    check("rst_fv", {63'd0, fetch_valid}, 64'd0);
    check("rst_halt", {63'd0, halt}, 64'd0);
    check("rst_misalign", {63'd0, misalign}, 64'd0);
    rst = 1'b1;
    check("boot_fv", {63'd0, fetch_valid}, 64'd0);
    tick();
    check("boot_fv_rise", {63'd0, fetch_valid}, 64'd1);

    // Fetch stall; commit_valid during FETCH must be ignored
    commit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_fv", {63'd0, fetch_valid}, 64'd1);
      check("stall_addr", {32'd0, fetch_addr}, {32'd0, RV});
    end
    commit_valid = 1'b0;
    check("stall_retired", retired, 64'd0);
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
    check("stall_exec_fv", {63'd0, fetch_valid}, 64'd0);
    do_commit("jal_to10", 3'd1, 32'h0000_0010, 32'd0, 32'd0, 32'd0, 1'b0, 32'h8000_0010, 1'b0);

    // Next-PC modes from 0x8000_0010, imm = -16
    do_fetch("seq");
    do_commit("seq", 3'd0, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 1'b0, 32'h8000_0014, 1'b0);
    goto_10();
    do_commit("jal", 3'd1, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 1'b0, 32'h8000_0000, 1'b0);
    goto_10();
    do_commit("jalr", 3'd2, 32'hFFFF_FFF0, 32'h8000_0101, 32'd0, 32'd0, 1'b0, 32'h8000_0100, 1'b0);
    goto_10();
    do_commit("br_nt", 3'd3, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'd0, 1'b0, 32'h8000_0014, 1'b0);
    goto_10();
    do_commit("br_t", 3'd3, 32'hFFFF_FFF0, 32'd1, 32'd0, 32'd0, 1'b0, 32'h8000_0000, 1'b0);
    goto_10();
    do_commit("trap", 3'd4, 32'hFFFF_FFF0, 32'd0, 32'h8000_1003, 32'd0, 1'b0, 32'h8000_1000, 1'b0);
    goto_10();
    do_commit("mret", 3'd5, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'h8000_0040, 1'b0, 32'h8000_0040, 1'b0);
    do_fetch("sel6");
    do_commit("sel6", 3'd6, 32'h0000_0100, 32'd0, 32'd0, 32'd0, 1'b0, 32'h8000_0044, 1'b0);

    // Halt, then further commits and fetch_ready are ignored
    do_fetch("halt");
    do_commit("halt", 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 32'h8000_0048, 1'b0);
    commit_valid = 1'b1; fetch_ready = 1'b1; npc_sel = 3'd1; imm = 32'h0000_0100;
    repeat (3) tick();
    commit_valid = 1'b0; fetch_ready = 1'b0;
    check("halted_pc", {32'd0, pc}, 64'h8000_0048);
    check("halted_retired", retired, exp_ret);
    check("halted_halt", {63'd0, halt}, 64'd1);
    check("halted_fv", {63'd0, fetch_valid}, 64'd0);

    // Reset out of HALT, then reset again in EXEC with a commit pending
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_ret = '0;
    check("rst2_halt", {63'd0, halt}, 64'd0);
    tick();
    do_fetch("rstmid");
    commit_valid = 1'b1; npc_sel = 3'd1; imm = 32'h0000_0100; rst = 1'b0;
    tick();
    commit_valid = 1'b0; rst = 1'b1;
    check("rstmid_pc", {32'd0, pc}, {32'd0, RV});
    check("rstmid_retired", retired, 64'd0);
    check("rstmid_fv", {63'd0, fetch_valid}, 64'd0);
    tick();
    check("rstmid_boot_fv", {63'd0, fetch_valid}, 64'd1);

    // Misaligned jal target
    do_fetch("mis");
`ifdef PC_GEN_MISALIGN_CHECK_EN
    do_commit("mis_jal", 3'd1, 32'd6, 32'd0, 32'h8000_2000, 32'd0, 1'b0, 32'h8000_2000, 1'b1);
    tick();
    check("mis_pulse_end", {63'd0, misalign}, 64'd0);
    check("mis_pc_hold", {32'd0, pc}, 64'h8000_2000);
`else
    do_commit("mis_jal", 3'd1, 32'd6, 32'd0, 32'h8000_2000, 32'd0, 1'b0, 32'h8000_0006, 1'b0);
    tick();
    check("mis_stays_low", {63'd0, misalign}, 64'd0);
    check("mis_pc_hold", {32'd0, pc}, 64'h8000_0006);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
